// File: rtl/br_pred_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | br_pred_unit                                                     |
// | Fetch PC register with direct-mapped branch prediction table;    |
// | resolves jump/beq/bne/jr, flushes on mispredict, trains table.   |
// | Optional macro: BR_STATS_EN (branch / mispredict counters).      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module br_pred_unit #(
  parameter int          IDX_W    = 6,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        res_valid,
  input  logic [31:0] res_pc,
  input  logic        res_pred_taken,
  input  logic [31:0] res_pred_target,
  input  logic [25:0] instr_index,
  input  logic [15:0] offset,
  input  logic [31:0] rd1,
  input  logic [31:0] rd2,
  input  logic        cu_jump,
  input  logic        cu_beq,
  input  logic        cu_bne,
  input  logic        cu_jr,
  output logic        flush,
  output logic [31:0] br_count,
  output logic [31:0] mispred_count
);

  localparam int c_entries = 1 << IDX_W;
  localparam int c_tag_w   = 30 - IDX_W;

  logic               r_valid  [c_entries];
  logic [c_tag_w-1:0] r_tag    [c_entries];
  logic [31:0]        r_target [c_entries];
  logic [1:0]         r_ctr    [c_entries];
  logic [31:0]        r_pc;

  // Fetch-side lookup
  logic [IDX_W-1:0]   w_f_idx;
  logic               w_f_hit;

  assign w_f_idx     = r_pc[IDX_W+1:2];
  assign w_f_hit     = r_valid[w_f_idx] && (r_tag[w_f_idx] == r_pc[31:IDX_W+2]);
  assign pc          = r_pc;
  assign pred_taken  = w_f_hit & r_ctr[w_f_idx][1];
  assign pred_target = pred_taken ? r_target[w_f_idx] : (r_pc + 32'd4);

  // Resolution
  logic [IDX_W-1:0]   w_r_idx;
  logic [c_tag_w-1:0] w_r_tag;
  logic               w_r_hit;
  logic [31:0]        w_br_off;
  logic [31:0]        w_act_target;
  logic [31:0]        w_act_next;
  logic               w_eq;
  logic               w_is_jmp;
  logic               w_act_taken;
  logic               w_res_go;
  logic               w_flush;

  assign w_r_idx = res_pc[IDX_W+1:2];
  assign w_r_tag = res_pc[31:IDX_W+2];
  assign w_r_hit = r_valid[w_r_idx] && (r_tag[w_r_idx] == w_r_tag);

  always_comb begin
    w_br_off = {{14{offset[15]}}, offset, 2'b00};
    w_eq     = (rd1 == rd2);
    w_is_jmp = cu_jump | cu_jr;
    if (cu_jump)
      w_act_target = {res_pc[31:28], instr_index, 2'b00};
    else if (cu_jr)
      w_act_target = rd1;
    else
      w_act_target = res_pc + w_br_off;
    w_act_taken = w_is_jmp | (cu_beq & w_eq) | (cu_bne & ~w_eq);
    w_act_next  = w_act_taken ? w_act_target : (res_pc + 32'd4);
    w_res_go    = res_valid & ~rst;
    w_flush     = w_res_go & ((w_act_taken != res_pred_taken) |
                              (w_act_taken & (w_act_target != res_pred_target)));
  end

  assign flush = w_flush;

  // A redirect wins over a stall so the squashed path is never held
  always_ff @(posedge clk) begin
    if (rst)
      r_pc <= RESET_PC;
    else if (w_flush)
      r_pc <= w_act_next;
    else if (!stall)
      r_pc <= pred_target;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < c_entries; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= 2'b01;
      end
    end else if (res_valid) begin
      if (w_act_taken) begin
        r_valid[w_r_idx] <= 1'b1;
        if (!w_r_hit)
          r_ctr[w_r_idx] <= w_is_jmp ? 2'b11 : 2'b10;
        else if (w_is_jmp || (r_ctr[w_r_idx] == 2'b11))
          r_ctr[w_r_idx] <= 2'b11;
        else
          r_ctr[w_r_idx] <= r_ctr[w_r_idx] + 2'b01;
      end else if (w_r_hit && (r_ctr[w_r_idx] != 2'b00)) begin
        r_ctr[w_r_idx] <= r_ctr[w_r_idx] - 2'b01;
      end
    end
  end

  // Tag/target carry no reset; validity alone guards them
  always_ff @(posedge clk) begin
    if (w_res_go && w_act_taken) begin
      r_tag[w_r_idx]    <= w_r_tag;
      r_target[w_r_idx] <= w_act_target;
    end
  end

`ifdef BR_STATS_EN
  logic        w_is_ctl;
  logic [31:0] r_br_count;
  logic [31:0] r_mispred_count;

  assign w_is_ctl = cu_jump | cu_beq | cu_bne | cu_jr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_br_count      <= 32'd0;
      r_mispred_count <= 32'd0;
    end else begin
      if (res_valid && w_is_ctl)
        r_br_count <= r_br_count + 32'd1;
      if (w_flush)
        r_mispred_count <= r_mispred_count + 32'd1;
    end
  end

  assign br_count      = r_br_count;
  assign mispred_count = r_mispred_count;
`else
  assign br_count      = 32'd0;
  assign mispred_count = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_br_pred_unit.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_br_pred_unit                                                  |
// | Directed scoreboard bench for br_pred_unit (default IDX_W=6).    |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_br_pred_unit;

  localparam logic [3:0] c_k_jump = 4'b1000;
  localparam logic [3:0] c_k_beq  = 4'b0100;
  localparam logic [3:0] c_k_bne  = 4'b0010;
  localparam logic [3:0] c_k_jr   = 4'b0001;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [31:0] pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        res_valid;
  logic [31:0] res_pc;
  logic        res_pred_taken;
  logic [31:0] res_pred_target;
  logic [25:0] instr_index;
  logic [15:0] offset;
  logic [31:0] rd1;
  logic [31:0] rd2;
  logic        cu_jump;
  logic        cu_beq;
  logic        cu_bne;
  logic        cu_jr;
  logic        flush;
  logic [31:0] br_count;
  logic [31:0] mispred_count;

  br_pred_unit dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .pc              (pc),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .res_valid       (res_valid),
    .res_pc          (res_pc),
    .res_pred_taken  (res_pred_taken),
    .res_pred_target (res_pred_target),
    .instr_index     (instr_index),
    .offset          (offset),
    .rd1             (rd1),
    .rd2             (rd2),
    .cu_jump         (cu_jump),
    .cu_beq          (cu_beq),
    .cu_bne          (cu_bne),
    .cu_jr           (cu_jr),
    .flush           (flush),
    .br_count        (br_count),
    .mispred_count   (mispred_count)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          exp_br  = 0;
  int          exp_mis = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic expect_v(input string tag, input logic [31:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic observe(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    total++;
    if (exp_q.size() == 0) begin
      bad++;
      $error("FAIL sb_underflow observed=%h expected=<none>", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s observed=%h expected=%h", t, obs, e);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_res();
    res_valid       = 1'b0;
    res_pc          = 32'd0;
    res_pred_taken  = 1'b0;
    res_pred_target = 32'd0;
    instr_index     = 26'd0;
    offset          = 16'd0;
    rd1             = 32'd0;
    rd2             = 32'd0;
    {cu_jump, cu_beq, cu_bne, cu_jr} = 4'b0000;
  endtask

  // Drives one resolution and checks flush in the same cycle
  task automatic resolve(input logic [3:0] kind, input logic [31:0] rpc,
                         input logic ptk, input logic [31:0] ptg,
                         input logic [25:0] idx, input logic [15:0] off,
                         input logic [31:0] a, input logic [31:0] b,
                         input string tag, input logic ef);
    res_valid       = 1'b1;
    res_pc          = rpc;
    res_pred_taken  = ptk;
    res_pred_target = ptg;
    instr_index     = idx;
    offset          = off;
    rd1             = a;
    rd2             = b;
    {cu_jump, cu_beq, cu_bne, cu_jr} = kind;
    expect_v(tag, {31'd0, ef});
    #1;
    observe({31'd0, flush});
    if (!rst) begin
      exp_br++;
      if (ef) exp_mis++;
    end
  endtask

  // Steer fetch to an address with a jr from an otherwise unused slot
  task automatic redirect(input logic [31:0] target);
    resolve(c_k_jr, 32'h0000_0FFC, 1'b0, 32'd0, 26'd0, 16'd0, target, 32'd0,
            "redir_flush", 1'b1);
    expect_v("redir_pc", target);
    tick();
    observe(pc);
    clear_res();
  endtask

  task automatic check_pred(input string tag, input logic tk, input logic [31:0] tg);
    expect_v({tag, "_taken"}, {31'd0, tk});
    observe({31'd0, pred_taken});
    expect_v({tag, "_target"}, tg);
    observe(pred_target);
  endtask

  task automatic check_pc_after_tick(input string tag, input logic [31:0] v);
    expect_v(tag, v);
    tick();
    observe(pc);
  endtask

  task automatic check_stats();
`ifdef BR_STATS_EN
    expect_v("br_count", exp_br);
    observe(br_count);
    expect_v("mispred_count", exp_mis);
    observe(mispred_count);
`else
    expect_v("br_count", 32'd0);
    observe(br_count);
    expect_v("mispred_count", 32'd0);
    observe(mispred_count);
`endif
  endtask

  initial begin
    clear_res();
    rst   = 1'b1;
    stall = 1'b0;
    tick();
    // Mismatching resolution during reset must neither flush nor train
    resolve(c_k_beq, 32'h10, 1'b0, 32'd0, 26'd0, 16'h4, 32'd5, 32'd5,
            "rst_flush", 1'b0);
    tick();
    clear_res();
    rst = 1'b0;
    expect_v("rst_pc", 32'h0);
    observe(pc);
    check_pred("rst_pred", 1'b0, 32'h4);
    check_stats();

    // 1: sequential fetch
    for (int i = 1; i <= 3; i++) begin
      check_pc_after_tick("seq_pc", 32'(4 * i));
      expect_v("seq_taken", 32'd0);
      observe({31'd0, pred_taken});
    end

    // 2: beq mispredict, allocate, later prediction
    resolve(c_k_beq, 32'h10, 1'b0, 32'd0, 26'd0, 16'h0004, 32'd5, 32'd5,
            "s2_flush", 1'b1);
    check_pc_after_tick("s2_pc", 32'h20);
    clear_res();
    redirect(32'h10);
    check_pred("s2_pred", 1'b1, 32'h20);
    check_pc_after_tick("s2_follow_pc", 32'h20);

    // 3: jump mispredict, then correctly predicted jump
    resolve(c_k_jump, 32'h3000_0040, 1'b0, 32'd0, 26'h0000100, 16'd0, 32'd0, 32'd0,
            "s3_flush", 1'b1);
    check_pc_after_tick("s3_pc", 32'h3000_0400);
    clear_res();
    redirect(32'h3000_0040);
    check_pred("s3_pred", 1'b1, 32'h3000_0400);
    resolve(c_k_jump, 32'h3000_0040, 1'b1, 32'h3000_0400, 26'h0000100, 16'd0, 32'd0, 32'd0,
            "s3_match_flush", 1'b0);
    check_pc_after_tick("s3_match_pc", 32'h3000_0400);
    clear_res();

    // 4: counter hysteresis; training also proceeds while stalled
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      resolve(c_k_beq, 32'h10, 1'b1, 32'h20, 26'd0, 16'h0004, 32'd5, 32'd5,
              "s4_train_flush", 1'b0);
      tick();
      clear_res();
    end
    expect_v("s4_stall_pc", 32'h3000_0400);
    observe(pc);
    stall = 1'b0;
    resolve(c_k_beq, 32'h10, 1'b1, 32'h20, 26'd0, 16'h0004, 32'd5, 32'd6,
            "s4_nt1_flush", 1'b1);
    check_pc_after_tick("s4_nt1_pc", 32'h14);
    clear_res();
    redirect(32'h10);
    check_pred("s4_after_nt1", 1'b1, 32'h20);
    resolve(c_k_beq, 32'h10, 1'b1, 32'h20, 26'd0, 16'h0004, 32'd5, 32'd6,
            "s4_nt2_flush", 1'b1);
    check_pc_after_tick("s4_nt2_pc", 32'h14);
    clear_res();
    redirect(32'h10);
    check_pred("s4_after_nt2", 1'b0, 32'h14);

    // 5: flush overrides stall, backward offset, reset mid-stall
    stall = 1'b1;
    resolve(c_k_bne, 32'h40, 1'b0, 32'd0, 26'd0, 16'hFFFF, 32'd1, 32'd2,
            "s5_flush", 1'b1);
    check_pc_after_tick("s5_pc", 32'h3C);
    clear_res();
    check_pc_after_tick("s5_hold_pc", 32'h3C);
    check_stats();
    rst = 1'b1;
    check_pc_after_tick("s5_rst_pc", 32'h0);
    rst     = 1'b0;
    exp_br  = 0;
    exp_mis = 0;
    check_stats();
    stall = 1'b0;
    redirect(32'h40);
    check_pred("s5_table_empty", 1'b0, 32'h44);

    // 6: aliasing entries, jr with wrong predicted target, correct not-taken
    resolve(c_k_beq, 32'h100, 1'b0, 32'd0, 26'd0, 16'h0010, 32'd7, 32'd7,
            "s6_flush", 1'b1);
    check_pc_after_tick("s6_pc", 32'h140);
    clear_res();
    redirect(32'h100);
    check_pred("s6_trained", 1'b1, 32'h140);
    redirect(32'h200);
    check_pred("s6_alias", 1'b0, 32'h204);
    resolve(c_k_jr, 32'h80, 1'b1, 32'h300, 26'd0, 16'd0, 32'h200, 32'd0,
            "s6_jr_tgt_flush", 1'b1);
    check_pc_after_tick("s6_jr_pc", 32'h200);
    clear_res();
    resolve(c_k_bne, 32'h500, 1'b0, 32'd0, 26'd0, 16'h0008, 32'd3, 32'd3,
            "s6_bne_nt_flush", 1'b0);
    check_pc_after_tick("s6_bne_pc", 32'h204);
    clear_res();
    check_stats();

    total++;
    assert (exp_q.size() == 0) else begin
      bad++;
      $error("FAIL sb_leftover observed=%0d expected=0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
